// File: rtl/fp_to_linear_serial_if.sv
// Handshake bundle between the float sample stream, the converter and the linear datapath.
// The master modport is the side that feeds words in and drains results.
interface fp_to_linear_serial_if #(
  parameter int EXP_W = 3,
  parameter int SIG_W = 4,
  parameter int OUT_W = 12
);
  logic             in_valid;
  logic             in_ready;
  logic             in_sign;
  logic [EXP_W-1:0] in_exp;
  logic [SIG_W-1:0] in_sig;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             busy;

  modport master (
    output in_valid, in_sign, in_exp, in_sig, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_sig, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/fp_to_linear_serial.sv
// Expands an {S, E, F} compressed float into a signed OUT_W-bit linear value,
// shifting the significand left one bit per cycle for E cycles.
module fp_to_linear_serial #(
  parameter int EXP_W = 3,
  parameter int SIG_W = 4,
  parameter int OUT_W = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  fp_to_linear_serial_if.slave    bus_io
);

  localparam int MAG_W = OUT_W - 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [MAG_W-1:0] mag_q, mag_d;
  logic [EXP_W-1:0] cnt_q, cnt_d;
  logic             sign_q, sign_d;
  logic [OUT_W-1:0] data_q, data_d;
  logic             accept;

  // A finished result may be drained and a new word taken on the same edge.
  assign bus_io.in_ready  = (state_q == IDLE) || ((state_q == DONE) && bus_io.out_ready);
  assign accept           = bus_io.in_valid && bus_io.in_ready;
  assign bus_io.out_valid = (state_q == DONE);
  assign bus_io.busy      = (state_q != IDLE);
  assign bus_io.out_data  = data_q;

  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    data_d  = data_q;

    case (state_q)
      IDLE: ;
      SHIFT: begin
        mag_d = mag_q << 1;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == EXP_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus_io.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      sign_d  = bus_io.in_sign;
      mag_d   = MAG_W'(bus_io.in_sig);
      cnt_d   = bus_io.in_exp;
      state_d = (bus_io.in_exp != '0) ? SHIFT : DONE;
    end

    // Result is captured only on entry to DONE (including DONE->DONE for E=0),
    // so it holds under back-pressure and stays visible in IDLE.
    if ((state_d == DONE) && ((state_q != DONE) || accept)) begin
      data_d = sign_d ? -{1'b0, mag_d} : {1'b0, mag_d};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mag_q   <= '0;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      data_q  <= data_d;
    end
  end

endmodule
